// File: rtl/blake2_pkg.sv
// Shared constants and types for the BLAKE2 compression engine.
// Holds the IVs, the SIGMA permutation table, the FSM state type and the counter widths.
package blake2_pkg;

    localparam int SIG_W = 4;

    localparam logic [63:0] IV64 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [31:0] IV32 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [3:0] SIGMA [10][16] = '{
        '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
        '{4'd14, 4'd10, 4'd4, 4'd8, 4'd9, 4'd15, 4'd13, 4'd6, 4'd1, 4'd12, 4'd0, 4'd2, 4'd11, 4'd7, 4'd5, 4'd3},
        '{4'd11, 4'd8, 4'd12, 4'd0, 4'd5, 4'd2, 4'd15, 4'd13, 4'd10, 4'd14, 4'd3, 4'd6, 4'd7, 4'd1, 4'd9, 4'd4},
        '{4'd7, 4'd9, 4'd3, 4'd1, 4'd13, 4'd12, 4'd11, 4'd14, 4'd2, 4'd6, 4'd5, 4'd10, 4'd4, 4'd0, 4'd15, 4'd8},
        '{4'd9, 4'd0, 4'd5, 4'd7, 4'd2, 4'd4, 4'd10, 4'd15, 4'd14, 4'd1, 4'd11, 4'd12, 4'd6, 4'd8, 4'd3, 4'd13},
        '{4'd2, 4'd12, 4'd6, 4'd10, 4'd0, 4'd11, 4'd8, 4'd3, 4'd4, 4'd13, 4'd7, 4'd5, 4'd15, 4'd14, 4'd1, 4'd9},
        '{4'd12, 4'd5, 4'd1, 4'd15, 4'd14, 4'd13, 4'd4, 4'd10, 4'd0, 4'd7, 4'd6, 4'd3, 4'd9, 4'd2, 4'd8, 4'd11},
        '{4'd13, 4'd11, 4'd7, 4'd14, 4'd12, 4'd1, 4'd3, 4'd9, 4'd5, 4'd0, 4'd15, 4'd4, 4'd8, 4'd6, 4'd2, 4'd10},
        '{4'd6, 4'd15, 4'd14, 4'd9, 4'd11, 4'd3, 4'd0, 4'd8, 4'd12, 4'd2, 4'd13, 4'd7, 4'd1, 4'd4, 4'd10, 4'd5},
        '{4'd10, 4'd2, 4'd8, 4'd4, 4'd7, 4'd6, 4'd1, 4'd5, 4'd15, 4'd11, 4'd9, 4'd14, 4'd3, 4'd12, 4'd13, 4'd0}
    };

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    // Half-round counter covers 0..2R-1.
    function automatic int step_w(input int r);
        return $clog2(2 * r);
    endfunction

endpackage

// File: rtl/blake2_g.sv
// Combinational BLAKE2 G mixing function; rotation amounts set per variant.
module blake2_g #(
    parameter int W  = 64,
    parameter int R1 = 32,
    parameter int R2 = 24,
    parameter int R3 = 16,
    parameter int R4 = 63
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_d,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b,
    output logic [W-1:0] o_c,
    output logic [W-1:0] o_d
);
    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
        return (v >> n) | (v << (W - n));
    endfunction

    logic [W-1:0] w_a1, w_b1, w_c1, w_d1;

    assign w_a1 = i_a + i_b + i_x;
    assign w_d1 = rotr(i_d ^ w_a1, R1);
    assign w_c1 = i_c + w_d1;
    assign w_b1 = rotr(i_b ^ w_c1, R2);
    assign o_a  = w_a1 + w_b1 + i_y;
    assign o_d  = rotr(w_d1 ^ o_a, R3);
    assign o_c  = w_c1 + o_d;
    assign o_b  = rotr(w_b1 ^ o_c, R4);

endmodule

// File: rtl/blake2_msg_sel.sv
// Picks the eight message words feeding the four G instances for the current half-round.
module blake2_msg_sel import blake2_pkg::*; #(
    parameter int W = 64
) (
    input  logic [15:0][W-1:0] i_m,
    input  logic [SIG_W-1:0]   i_sig,
    input  logic               i_odd,
    output logic [3:0][W-1:0]  o_x,
    output logic [3:0][W-1:0]  o_y
);
    logic [SIG_W-1:0] w_row;

    // Rows above 9 never occur; clamp so the table index stays in range.
    assign w_row = (i_sig > 4'd9) ? '0 : i_sig;

    always_comb begin
        o_x = '0;
        o_y = '0;
        for (int i = 0; i < 4; i++) begin
            o_x[i] = i_m[SIGMA[w_row][{i_odd, 2'(i), 1'b0}]];
            o_y[i] = i_m[SIGMA[w_row][{i_odd, 2'(i), 1'b1}]];
        end
    end

endmodule

// File: rtl/blake2_compress.sv
// Iterative BLAKE2 compression F(h, m, t, f): one half-round per cycle through four G units.
module blake2_compress import blake2_pkg::*; #(
    parameter int W  = 64,
    parameter int R  = 12,
    parameter int R1 = 32,
    parameter int R2 = 24,
    parameter int R3 = 16,
    parameter int R4 = 63
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [8*W-1:0] h_i,
    input  logic [16*W-1:0] m_i,
    input  logic [2*W-1:0] t_i,
    input  logic           f_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [8*W-1:0] h_o
);
    localparam int STEP_W = step_w(R);
    localparam logic [STEP_W-1:0] LAST = STEP_W'(2 * R - 1);

    state_t               r_state;
    logic [7:0][W-1:0]    r_h;
    logic [15:0][W-1:0]   r_m;
    logic [15:0][W-1:0]   r_v;
    logic [STEP_W-1:0]    r_step;
    logic [SIG_W-1:0]     r_sig;
    logic                 r_ready;
    logic                 r_valid;
    logic [7:0][W-1:0]    r_ho;

    logic [7:0][W-1:0]    w_iv;
    logic [15:0][W-1:0]   w_init;
    logic [15:0][W-1:0]   w_vn;
    logic [7:0][W-1:0]    w_hn;
    logic [3:0][W-1:0]    w_ga, w_gb, w_gc, w_gd, w_na, w_nb, w_nc, w_nd;
    logic [3:0][W-1:0]    w_x, w_y;
    logic                 w_odd;

    assign w_odd   = r_step[0];
    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign h_o     = r_ho;

    always_comb begin
        w_iv = '0;
        for (int k = 0; k < 8; k++)
            w_iv[k] = (W == 64) ? W'(IV64[k]) : W'(IV32[k]);
    end

    always_comb begin
        w_init     = {w_iv, h_i};
        w_init[12] = w_iv[4] ^ t_i[W-1:0];
        w_init[13] = w_iv[5] ^ t_i[2*W-1:W];
        w_init[14] = w_iv[6] ^ {W{f_i}};
    end

    // Even steps mix columns, odd steps mix diagonals; the write-back uses the same map.
    always_comb begin
        w_ga = '0; w_gb = '0; w_gc = '0; w_gd = '0;
        w_vn = r_v;
        for (int i = 0; i < 4; i++) begin
            w_ga[i] = r_v[i];
            w_vn[i] = w_na[i];
            if (w_odd) begin
                w_gb[i] = r_v[4 + ((i + 1) % 4)];
                w_gc[i] = r_v[8 + ((i + 2) % 4)];
                w_gd[i] = r_v[12 + ((i + 3) % 4)];
                w_vn[4 + ((i + 1) % 4)]  = w_nb[i];
                w_vn[8 + ((i + 2) % 4)]  = w_nc[i];
                w_vn[12 + ((i + 3) % 4)] = w_nd[i];
            end else begin
                w_gb[i] = r_v[4 + i];
                w_gc[i] = r_v[8 + i];
                w_gd[i] = r_v[12 + i];
                w_vn[4 + i]  = w_nb[i];
                w_vn[8 + i]  = w_nc[i];
                w_vn[12 + i] = w_nd[i];
            end
        end
    end

    always_comb begin
        w_hn = '0;
        for (int k = 0; k < 8; k++)
            w_hn[k] = r_h[k] ^ w_vn[k] ^ w_vn[8 + k];
    end

    blake2_msg_sel #(.W(W)) u_msg_sel (
        .i_m   (r_m),
        .i_sig (r_sig),
        .i_odd (w_odd),
        .o_x   (w_x),
        .o_y   (w_y)
    );

    for (genvar g = 0; g < 4; g++) begin : g_mix
        blake2_g #(.W(W), .R1(R1), .R2(R2), .R3(R3), .R4(R4)) u_g (
            .i_a (w_ga[g]), .i_b (w_gb[g]), .i_c (w_gc[g]), .i_d (w_gd[g]),
            .i_x (w_x[g]),  .i_y (w_y[g]),
            .o_a (w_na[g]), .o_b (w_nb[g]), .o_c (w_nc[g]), .o_d (w_nd[g])
        );
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_m     <= '0;
            r_v     <= '0;
            r_step  <= '0;
            r_sig   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_ho    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (valid_i && r_ready) begin
                        r_ready <= 1'b0;
                        r_h     <= h_i;
                        r_m     <= m_i;
                        r_v     <= w_init;
                        r_step  <= '0;
                        r_sig   <= '0;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_v    <= w_vn;
                    r_step <= r_step + STEP_W'(1);
                    // SIGMA row advances after each diagonal step and wraps past 9.
                    if (w_odd)
                        r_sig <= (r_sig == 4'd9) ? '0 : r_sig + 4'd1;
                    if (r_step == LAST) begin
                        r_ho    <= w_hn;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_compress.sv
// Randomised scoreboard bench for blake2_compress, BLAKE2b and BLAKE2s instances.
module tb_blake2_compress;

    localparam logic [63:0] IVB [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [63:0] IVS [8] = '{
        64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
        64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19
    };
    localparam int SIGT [10][16] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
        '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
        '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
        '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
        '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
        '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
        '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
        '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
        '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
        '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}
    };
    localparam int GI [8][4] = '{
        '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
    };

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    logic           valid_i, ready_o, f_i, valid_o, ready_i;
    logic [511:0]   h_i, h_o;
    logic [1023:0]  m_i;
    logic [127:0]   t_i;
    logic           s_valid_i, s_ready_o, s_f_i, s_valid_o, s_ready_i;
    logic [255:0]   s_h_i, s_h_o;
    logic [511:0]   s_m_i;
    logic [63:0]    s_t_i;

    blake2_compress dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
        .h_i(h_i), .m_i(m_i), .t_i(t_i), .f_i(f_i),
        .valid_o(valid_o), .ready_i(ready_i), .h_o(h_o)
    );

    blake2_compress #(.W(32), .R(10), .R1(16), .R2(12), .R3(8), .R4(7)) dut_s (
        .clk(clk), .nreset(nreset), .valid_i(s_valid_i), .ready_o(s_ready_o),
        .h_i(s_h_i), .m_i(s_m_i), .t_i(s_t_i), .f_i(s_f_i),
        .valid_o(s_valid_o), .ready_i(s_ready_i), .h_o(s_h_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rnd_bp = 1'b0;
    logic [511:0] exp_q[$];
    logic [255:0] exps_q[$];
    int acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] mk;
        mk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        x = x & mk;
        return ((x >> n) | (x << (w - n))) & mk;
    endfunction

    // Straight BLAKE2 F over 64-bit containers; words are masked to w bits.
    function automatic logic [511:0] ref_f(input int w, input int nr, input int r1, input int r2,
                                           input int r3, input int r4, input logic [511:0] hp,
                                           input logic [1023:0] mp, input logic [63:0] t0,
                                           input logic [63:0] t1, input bit f);
        logic [63:0] mk, x, y;
        logic [63:0] v[16];
        logic [63:0] m[16];
        logic [63:0] h[8];
        logic [511:0] res;
        int a, b, c, d;
        mk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int k = 0; k < 16; k++) m[k] = mp[k*64 +: 64] & mk;
        for (int k = 0; k < 8; k++) begin
            h[k]     = hp[k*64 +: 64] & mk;
            v[k]     = h[k];
            v[8 + k] = (w == 64) ? IVB[k] : IVS[k];
        end
        v[12] = v[12] ^ (t0 & mk);
        v[13] = v[13] ^ (t1 & mk);
        if (f) v[14] = v[14] ^ mk;
        for (int r = 0; r < nr; r++) begin
            for (int g = 0; g < 8; g++) begin
                a = GI[g][0]; b = GI[g][1]; c = GI[g][2]; d = GI[g][3];
                x = m[SIGT[r % 10][2*g]];
                y = m[SIGT[r % 10][2*g + 1]];
                v[a] = (v[a] + v[b] + x) & mk;
                v[d] = rotr(v[d] ^ v[a], r1, w);
                v[c] = (v[c] + v[d]) & mk;
                v[b] = rotr(v[b] ^ v[c], r2, w);
                v[a] = (v[a] + v[b] + y) & mk;
                v[d] = rotr(v[d] ^ v[a], r3, w);
                v[c] = (v[c] + v[d]) & mk;
                v[b] = rotr(v[b] ^ v[c], r4, w);
            end
        end
        res = '0;
        for (int k = 0; k < 8; k++) res[k*64 +: 64] = h[k] ^ v[k] ^ v[k + 8];
        return res;
    endfunction

    function automatic logic [255:0] pack32(input logic [511:0] p);
        logic [255:0] o;
        o = '0;
        for (int k = 0; k < 8; k++) o[k*32 +: 32] = p[k*64 +: 32];
        return o;
    endfunction

    function automatic logic [511:0] pack32m(input logic [1023:0] p);
        logic [511:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[k*32 +: 32] = p[k*64 +: 32];
        return o;
    endfunction

    // Scoreboard monitors: one pop per completed handshake.
    always @(negedge clk) begin
        if (nreset && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_b_unexpected: actual=%h required=none", h_o);
            end else begin
                check("sb_b", h_o, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (nreset && s_valid_o && s_ready_i) begin
            if (exps_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_s_unexpected: actual=%h required=none", s_h_o);
            end else begin
                check("sb_s", 512'(s_h_o), 512'(exps_q.pop_front()));
            end
        end
    end

    always @(negedge clk)
        if (nreset && valid_i && ready_o) acc_q.push_back(cyc);

    task automatic send_b(input logic [511:0] hp, input logic [1023:0] mp,
                          input logic [63:0] t0, input logic [63:0] t1, input bit f);
        int guard;
        exp_q.push_back(ref_f(64, 12, 32, 24, 16, 63, hp, mp, t0, t1, f));
        h_i = hp; m_i = mp; t_i = {t1, t0}; f_i = f; valid_i = 1'b1;
        guard = 0;
        while (!ready_o && guard < 300) begin
            @(posedge clk); #1;
            guard++;
            if (rnd_bp) ready_i = 1'($urandom_range(0, 1));
        end
        if (!ready_o) begin
            void'(exp_q.pop_back());
            check("send_b_timeout", 512'(ready_o), 512'(1));
            valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        if (rnd_bp) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send_s(input logic [511:0] hp, input logic [1023:0] mp,
                          input logic [63:0] t0, input logic [63:0] t1, input bit f);
        int guard;
        exps_q.push_back(pack32(ref_f(32, 10, 16, 12, 8, 7, hp, mp, t0, t1, f)));
        s_h_i = pack32(hp); s_m_i = pack32m(mp); s_t_i = {t1[31:0], t0[31:0]};
        s_f_i = f; s_valid_i = 1'b1;
        guard = 0;
        while (!s_ready_o && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!s_ready_o) begin
            void'(exps_q.pop_back());
            check("send_s_timeout", 512'(s_ready_o), 512'(1));
            s_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        int guard;
        guard = 0;
        while ((exp_q.size() > 0 || exps_q.size() > 0) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
            if (rnd_bp) ready_i = 1'($urandom_range(0, 1));
        end
        ready_i = 1'b1;
        check("drain", 512'(exp_q.size() + exps_q.size()), 512'(0));
    endtask

    function automatic logic [1023:0] rnd_blk();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [511:0]  abc_h, abcs_h, iv_h, hold;
    logic [1023:0] abc_m, rblk;
    int n0, acc0;

    initial begin
        nreset = 1'b0;
        valid_i = 1'b0; ready_i = 1'b1; h_i = '0; m_i = '0; t_i = '0; f_i = 1'b0;
        s_valid_i = 1'b0; s_ready_i = 1'b1; s_h_i = '0; s_m_i = '0; s_t_i = '0; s_f_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            iv_h[k*64 +: 64]   = IVB[k];
            abcs_h[k*64 +: 64] = IVS[k];
        end
        abc_h = iv_h;
        abc_h[63:0] = abc_h[63:0] ^ 64'h01010040;
        abcs_h[63:0] = abcs_h[63:0] ^ 64'h01010020;
        abc_m = '0;
        abc_m[63:0] = 64'h0000000000636261;

        #12;
        check("rst_ready", 512'(ready_o), 512'(0));
        check("rst_valid", 512'({valid_o, s_valid_o}), 512'(0));
        check("rst_h_o", h_o, 512'(0));
        @(negedge clk) nreset = 1'b1;
        @(posedge clk); #1;
        check("ready_rise", 512'({ready_o, s_ready_o}), 512'(3));

        // BLAKE2b "abc" with exact latency
        send_b(abc_h, abc_m, 64'd3, 64'd0, 1'b1);
        repeat (23) @(posedge clk);
        #1 check("lat_b_early", 512'(valid_o), 512'(0));
        @(posedge clk); #1;
        check("lat_b", 512'(valid_o), 512'(1));
        check("kat_b", 512'(h_o[63:0]), 512'(64'h0D4D1C983FA580BA));
        wait_empty();

        // Backpressure with ignored request pulses
        ready_i = 1'b0;
        send_b(abc_h, abc_m, 64'd3, 64'd0, 1'b1);
        n0 = 0;
        while (!valid_o && n0 < 100) begin @(posedge clk); #1; n0++; end
        check("bp_valid", 512'(valid_o), 512'(1));
        hold = h_o;
        n0 = acc_q.size();
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            h_i = rnd_blk()[511:0];
            @(posedge clk); #1;
            check("bp_hold_h", h_o, hold);
            check("bp_hold_flags", 512'({valid_o, ready_o}), 512'(2));
        end
        valid_i = 1'b0;
        check("bp_no_accept", 512'(acc_q.size() - n0), 512'(0));
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 512'({valid_o, ready_o}), 512'(1));
        wait_empty();

        // Back-to-back with valid held high
        n0 = acc_q.size();
        exp_q.push_back(ref_f(64, 12, 32, 24, 16, 63, abc_h, abc_m, 64'd3, 64'd0, 1'b1));
        exp_q.push_back(ref_f(64, 12, 32, 24, 16, 63, abc_h, abc_m, 64'd3, 64'd0, 1'b1));
        h_i = abc_h; m_i = abc_m; t_i = 128'd3; f_i = 1'b1; valid_i = 1'b1;
        acc0 = 0;
        while (acc_q.size() < n0 + 2 && acc0 < 200) begin @(posedge clk); #1; acc0++; end
        valid_i = 1'b0;
        if (acc_q.size() >= n0 + 2)
            check("b2b_gap", 512'(acc_q[n0 + 1] - acc_q[n0]), 512'(26));
        else
            check("b2b_accepts", 512'(acc_q.size() - n0), 512'(2));
        wait_empty();

        // Reset in the middle of the rounds
        send_b(abc_h, abc_m, 64'd3, 64'd0, 1'b1);
        repeat (7) @(posedge clk);
        #1 nreset = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("rst_mid_h_o", h_o, 512'(0));
        check("rst_mid_flags", 512'({valid_o, ready_o}), 512'(0));
        check("rst_mid_v", 512'(dut.r_v != '0), 512'(0));
        @(negedge clk) nreset = 1'b1;
        @(posedge clk); #1;
        send_b(abc_h, abc_m, 64'd3, 64'd0, 1'b1);
        wait_empty();

        // Non-final block, t=128, zero message
        send_b(iv_h, '0, 64'd128, 64'd0, 1'b0);
        wait_empty();

        // Randomised blocks with random downstream stalls
        rnd_bp = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rblk = rnd_blk();
            send_b(rblk[511:0], rnd_blk(), {$urandom, $urandom}, 64'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end
        wait_empty();
        rnd_bp = 1'b0;

        // BLAKE2s instance
        send_s(abcs_h, abc_m, 64'd3, 64'd0, 1'b1);
        repeat (19) @(posedge clk);
        #1 check("lat_s_early", 512'(s_valid_o), 512'(0));
        @(posedge clk); #1;
        check("lat_s", 512'(s_valid_o), 512'(1));
        check("kat_s", 512'(s_h_o[31:0]), 512'(32'h8C5E8C50));
        wait_empty();
        for (int i = 0; i < 6; i++) begin
            rblk = rnd_blk();
            send_s(rblk[511:0], rnd_blk(), 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
        end
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/blake2_compress.md
# blake2_compress

Iterative BLAKE2 compression-function engine, F(h, m, t, f). It owns the working vector v[0..15] and sequences rounds. Each cycle it drives four instances of the team's combinational G mixing module with the correct a/b/c/d/x/y operands and consumes their outputs. It sits between the block buffer / padding logic upstream and the chaining-value register downstream. One 128·W-bit block is compressed per transaction.

## Interface
Parameters:
- W, 64: word width; 64 = BLAKE2b, 32 = BLAKE2s.
- R, 12: round count; 12 for W=64, 10 for W=32.
- R1, 32: G rotation 1; 16 for W=32.
- R2, 24: G rotation 2; 12 for W=32.
- R3, 16: G rotation 3; 8 for W=32.
- R4, 63: G rotation 4; 7 for W=32.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- nreset  in  1  asynchronous active-low reset.
- valid_i  in  1  block request valid.
- ready_o  out  1  engine idle, accepts a request.
- h_i  in  8·W  chaining value; word k at [k·W +: W].
- m_i  in  16·W  message block; word j at [j·W +: W], little-endian words.
- t_i  in  2·W  byte offset counter; t0 at [W-1:0], t1 at [2W-1:W].
- f_i  in  1  final-block flag.
- valid_o  out  1  h_o valid.
- ready_i  in  1  downstream accepts h_o.
- h_o  out  8·W  new chaining value, same packing as h_i.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE: ready_o=1. When valid_i&ready_o, the engine:
  - registers h_i and m_i;
  - loads v[0..7]=h_i, v[8..15]=IV[0..7];
  - sets v12^=t0, v13^=t1, v14^=(f_i ? all-ones : 0);
  - clears step=0 and sig=0, then goes to ROUND.
- ROUND: one half-round per cycle.
  - Even step (column): G(v0,v4,v8,v12,m[s0],m[s1]), G(v1,v5,v9,v13,s2,s3), G(v2,v6,v10,v14,s4,s5), G(v3,v7,v11,v15,s6,s7).
  - Odd step (diagonal): G(v0,v5,v10,v15,s8,s9), G(v1,v6,v11,v12,s10,s11), G(v2,v7,v8,v13,s12,s13), G(v3,v4,v9,v14,s14,s15).
  - s_k=SIGMA[sig][k].
  - step counts 0..2R-1.
  - sig advances after each odd step and wraps 9→0, so BLAKE2b rounds 10 and 11 reuse rows 0 and 1. There is no modulo divider.
- On step==2R-1, the engine registers h_o = h ^ v'[0..7] ^ v'[8..15], where v' is the G outputs of that cycle. valid_o is set and the state goes to DONE.
- DONE: h_o and valid_o are held stable while ready_i=0. When valid_o&ready_i, valid_o clears and the state returns to IDLE. ready_o is 1 from the next cycle; there is no same-cycle re-accept.
- All additions are mod 2^W; carries are discarded.
- valid_i is ignored outside IDLE. Inputs are sampled only at the accept edge.

## Timing
- Reset values: state=IDLE, ready_o=0, valid_o=0, h_o=0, v=0, step=0, sig=0.
- ready_o rises on the first clk edge after nreset deasserts.
- Latency: acceptance on edge E0 gives valid_o=1 after edge E2R (24 cycles for b, 20 for s).
- Throughput: one block per 2R+2 cycles with ready_i tied high.
- Reset asserted mid-ROUND or in DONE aborts immediately with the reset values. A partial result is never presented.
- ready_o and valid_o are registered, not combinational from inputs.

## Structure
- blake2_pkg holds:
  - IV64[0..7] and IV32[0..7];
  - SIGMA[10][16] as 4-bit indices;
  - the state enum;
  - the step and sig counter widths, $clog2(2R) and 4.
- Sub-module blake2_msg_sel: combinational. Inputs are m, sig and step[0]; outputs are eight x/y words for the four G instances. This keeps the SIGMA muxing out of the FSM.
- The four G instances are wired from the v register through a column/diagonal operand mux and back through the inverse mux.

## Test plan
- BLAKE2b "abc" (RFC 7693 App. A): h_i=IV64 with h0^=64'h01010040; m word0=64'h0000000000636261, rest 0; t=3; f=1 → after 24 cycles valid_o=1, h_o word0=64'h0D4D1C983FA580BA.
- BLAKE2s "abc" (W=32, R=10, rot 16/12/8/7): h0=IV32[0]^32'h01010020, m0=32'h00636261, t=3, f=1 → h_o word0=32'h8C5E8C50 after 20 cycles.
- Backpressure: hold ready_i=0 for 10 cycles → h_o stable, ready_o=0, valid_o=1 throughout; valid_i pulses ignored. Then release → IDLE, ready_o=1 next cycle.
- Back-to-back: two "abc" requests with ready_i=1 → identical h_o, accept edges 26 cycles apart.
- Reset at step 7 → valid_o, h_o, v all 0 immediately. A fresh "abc" afterwards gives the correct digest.
- f=0 with t=128, m all zero, h=IV64 → h_o matches the software model (checks the v14 inversion gating and t1=0 path).
